// File: rtl/phase_seq_pkg.sv
// Shared types and helpers for the instruction-phase sequencer.
package phase_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STEP,
        DRAIN
    } state_t;

    // Width of a phase index; never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/phase_seq.sv
// Instruction-phase sequencer: one-hot phase vector over NPH phases per
// cycle with run, single-step, stall and end-of-cycle stop.
module phase_seq
    import phase_seq_pkg::*;
#(
    parameter  int unsigned NPH = 4,
    parameter  int unsigned CW  = 16,
    localparam int unsigned IW  = idx_width(NPH)
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           start,
    input  logic           stop,
    input  logic           step,
    input  logic           stall,
    output logic [NPH-1:0] q,
    output logic [IW-1:0]  ph_idx,
    output logic           running,
    output logic [CW-1:0]  cyc_cnt,
    output logic           cyc_done
);

    state_t         state, state_n;
    logic [IW-1:0]  idx_n;
    logic [NPH-1:0] q_n;
    logic [CW-1:0]  cnt_n;
    logic           done_n;
    logic           last;

    assign last = (ph_idx == IW'(NPH - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            ph_idx   <= '0;
            q        <= '0;
            running  <= 1'b0;
            cyc_cnt  <= '0;
            cyc_done <= 1'b0;
        end else begin
            state    <= state_n;
            ph_idx   <= idx_n;
            q        <= q_n;
            running  <= (state_n != IDLE);
            cyc_cnt  <= cnt_n;
            cyc_done <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = ph_idx;
        cnt_n   = cyc_cnt;
        done_n  = 1'b0;
        q_n     = '0;

        unique case (state)
            IDLE: begin
                if (!stop) begin
                    if (start) begin
                        state_n = RUN;
                        idx_n   = '0;
                    end else if (step) begin
                        state_n = STEP;
                        idx_n   = '0;
                    end
                end
            end
            default: begin
                if (stall) begin
                    // A stop during a stall is latched into DRAIN so it is not lost.
                    if (state == RUN && stop)
                        state_n = DRAIN;
                end else if (last) begin
                    cnt_n  = cyc_cnt + CW'(1);
                    done_n = 1'b1;
                    idx_n  = '0;
                    if (state != RUN || stop)
                        state_n = IDLE;
                end else begin
                    idx_n = ph_idx + IW'(1);
                    if (state == RUN && stop)
                        state_n = DRAIN;
                end
            end
        endcase

        // q is the decode of the next index so it changes on the same edge.
        if (state_n != IDLE)
            q_n[idx_n] = 1'b1;
    end

endmodule

// File: tb/tb_phase_seq.sv
// Scoreboarded bench for phase_seq (NPH=4, CW=8).
module tb_phase_seq;

    localparam int NPH = 4;
    localparam int CW  = 8;

    logic           CLK   = 1'b0;
    logic           RST   = 1'b1;
    logic           start = 1'b0;
    logic           stop  = 1'b0;
    logic           step  = 1'b0;
    logic           stall = 1'b0;
    logic [NPH-1:0] q;
    logic [1:0]     ph_idx;
    logic           running;
    logic [CW-1:0]  cyc_cnt;
    logic           cyc_done;

    phase_seq #(.NPH(NPH), .CW(CW)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .stop     (stop),
        .step     (step),
        .stall    (stall),
        .q        (q),
        .ph_idx   (ph_idx),
        .running  (running),
        .cyc_cnt  (cyc_cnt),
        .cyc_done (cyc_done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int q;
        int idx;
        int run;
        int cnt;
        int done;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Behavioural reference: 0 idle, 1 run, 2 step, 3 drain.
    int m_mode = 0;
    int m_ph   = 0;
    int m_cnt  = 0;
    int m_done = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_ph   = 0;
        m_cnt  = 0;
        m_done = 0;
    endtask

    task automatic model(input bit s, input bit p, input bit t, input bit l);
        m_done = 0;
        if (m_mode == 0) begin
            if (!p && s) begin
                m_mode = 1; m_ph = 0;
            end else if (!p && t) begin
                m_mode = 2; m_ph = 0;
            end
        end else if (l) begin
            if (m_mode == 1 && p) m_mode = 3;
        end else if (m_ph == NPH - 1) begin
            m_cnt  = (m_cnt + 1) % (1 << CW);
            m_done = 1;
            m_ph   = 0;
            if (m_mode != 1 || p) m_mode = 0;
        end else begin
            m_ph = m_ph + 1;
            if (m_mode == 1 && p) m_mode = 3;
        end
    endtask

    task automatic tick(input bit s, input bit p, input bit t, input bit l);
        exp_t e;
        exp_t g;
        start = s; stop = p; step = t; stall = l;
        model(s, p, t, l);
        e.q    = (m_mode == 0) ? 0 : (1 << m_ph);
        e.idx  = (m_mode == 0) ? 0 : m_ph;
        e.run  = (m_mode != 0) ? 1 : 0;
        e.cnt  = m_cnt;
        e.done = m_done;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        g = sb.pop_front();
        chk("q",        32'(q),        g.q);
        chk("ph_idx",   32'(ph_idx),   g.idx);
        chk("running",  32'(running),  g.run);
        chk("cyc_cnt",  32'(cyc_cnt),  g.cnt);
        chk("cyc_done", 32'(cyc_done), g.done);
        start = 0; stop = 0; step = 0; stall = 0;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
    endtask

    task automatic run_to_phase(input int ph);
        for (int i = 0; i < 16 && m_ph != ph; i++) tick(0, 0, 0, 0);
        chk("reach_phase", 32'(ph_idx), ph);
    endtask

    task automatic run_to_idle();
        for (int i = 0; i < 16 && m_mode != 0; i++) tick(0, 0, 0, 0);
        chk("reach_idle", 32'(running), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_q"},        32'(q),        0);
        chk({tag, "_ph_idx"},   32'(ph_idx),   0);
        chk({tag, "_running"},  32'(running),  0);
        chk({tag, "_cyc_cnt"},  32'(cyc_cnt),  0);
        chk({tag, "_cyc_done"}, 32'(cyc_done), 0);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk_all_zero("reset");
        model_reset();
        RST = 0;

        // Free run: three full cycles, then stop pulsed while q=0010.
        tick(1, 0, 0, 0);
        idle_ticks(12);
        chk("three_cycles", 32'(cyc_cnt), 3);
        run_to_phase(1);
        tick(0, 1, 0, 0);
        tick(1, 0, 0, 0);           // start during DRAIN is ignored
        run_to_idle();
        chk("stop_cnt", 32'(cyc_cnt), 4);
        idle_ticks(2);

        // Single step, with a second step and a stop mid-step ignored.
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        tick(0, 1, 0, 0);
        run_to_idle();
        chk("step_cnt", 32'(cyc_cnt), 5);
        idle_ticks(2);

        // Stall three clocks at q=0100 with a stop raised during the stall.
        tick(1, 0, 0, 0);
        run_to_phase(2);
        tick(0, 0, 0, 1);
        tick(0, 1, 0, 1);
        tick(0, 0, 0, 1);
        chk("stall_hold", 32'(q), 4);
        run_to_idle();
        chk("stall_cnt", 32'(cyc_cnt), 6);

        // Stop on the unstalled last-phase edge goes straight to IDLE.
        tick(1, 0, 0, 0);
        run_to_phase(3);
        tick(0, 1, 0, 0);
        chk("last_edge_stop", 32'(running), 0);

        // start+stop in IDLE stays idle; start+step runs freely.
        tick(1, 1, 0, 0);
        tick(1, 1, 1, 0);
        chk("start_stop_idle", 32'(running), 0);
        tick(1, 0, 1, 0);
        idle_ticks(9);
        chk("start_step_runs", 32'(running), 1);
        tick(0, 1, 0, 0);
        run_to_idle();

        // Run until the counter wraps, then reset asynchronously at phase 2.
        tick(1, 0, 0, 0);
        for (int i = 0; i < 1200 && !(m_cnt == 0 && m_done == 1); i++) tick(0, 0, 0, 0);
        chk("wrap_cnt", 32'(cyc_cnt), 0);
        chk("wrap_done", 32'(cyc_done), 1);
        run_to_phase(2);
        #2;
        RST = 1;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        @(negedge CLK);
        RST = 0;
        idle_ticks(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phase_seq.md
# phase_seq

Parametrised instruction-phase sequencer for the pipeline control path. Drives a one-hot phase vector through NPH phases per instruction cycle and counts completed cycles. Adds single-step, stall and graceful (end-of-cycle) stop over the fixed four-phase generation. Sits between the front-panel/debug controls and the pipeline stage enables.

## Interface
- NPH, 4, number of phases per instruction cycle; must be ≥ 2.
- CW, 16, width of the completed-cycle counter.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- start  in  1  level, sampled each edge; begins free-running from IDLE.
- stop  in  1  level, sampled each edge; requests a stop at the end of the current cycle.
- step  in  1  level, sampled each edge; runs exactly one cycle from IDLE.
- stall  in  1  freezes phase advance while high.
- q  out  NPH  one-hot phase vector; all zeros when idle.
- ph_idx  out  $clog2(NPH)  index of the active phase; 0 when idle.
- running  out  1  high in any non-IDLE state.
- cyc_cnt  out  CW  completed cycles, modulo 2^CW.
- cyc_done  out  1  one-clock pulse per completed cycle.

## Operation
- States: IDLE, RUN (free-running), STEP (one cycle, then IDLE), DRAIN (RUN with a stop pending).
- Reset values (asynchronous): state IDLE, q 0, ph_idx 0, running 0, cyc_cnt 0, cyc_done 0.
- IDLE, priority stop > start > step:
  - stop held: stay in IDLE.
  - start: go to RUN.
  - step: go to STEP.
  - Entry to RUN or STEP loads phase 0.
- Advance: in RUN, STEP or DRAIN with stall low, phase i → i+1. With stall high, q and ph_idx hold.
- Last phase (NPH-1) advancing, unstalled:
  - RUN: wrap to phase 0.
  - STEP or DRAIN: go to IDLE, q = 0.
  - All cases: cyc_cnt increments and cyc_done pulses.
- stop seen in RUN goes to DRAIN, even while stalled.
  - If sampled on the unstalled last-phase edge, go directly to IDLE.
  - A stop is never lost and never cuts a cycle short.
- stop seen in STEP has no effect; the step completes anyway.
- start or step seen in RUN, STEP or DRAIN: ignored. DRAIN cannot be cancelled by start.
- cyc_cnt wraps from 2^CW-1 to 0 with no flag.
- RST asserted mid-cycle: immediate return to IDLE. Partial cycles are not counted.

## Timing
- Start latency: start high at edge k → q = 1 (phase 0) and running = 1 after edge k.
- One phase per unstalled clock. Free-running period is exactly NPH clocks.
- cyc_done and the cyc_cnt update are registered. Both are visible after the edge that leaves phase NPH-1.
- After the final cycle of STEP or DRAIN, cyc_done is high in the same clock in which q is already 0 and running is 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package phase_seq_pkg holds:
  - the state enum typedef (IDLE, RUN, STEP, DRAIN);
  - a helper function for the ph_idx width.
- Single module with no sub-modules.
- Phase is held as a binary index. q is a registered one-hot decode of that index, updated on the same edge.

## Test plan
All scenarios use NPH=4, CW=8.
- Reset then start pulse: q sequence 0001, 0010, 0100, 1000, 0001…. cyc_done pulses every 4 clocks. cyc_cnt counts 1, 2, 3.
- stop pulsed while q=0010: phases continue to 1000, then q=0000 and running=0. cyc_cnt is incremented exactly once for that cycle.
- step pulse from IDLE: exactly four phases, then IDLE with cyc_cnt +1. A second step while running is ignored.
- stall high for 3 clocks at q=0100: q holds 0100 for 3 extra clocks. Period becomes 7 clocks. A stop raised during the stall is honoured at the end of the cycle.
- start and stop together in IDLE: remains IDLE. start and step together: enters RUN and does not stop after one cycle.
- Preload run to cyc_cnt=255, complete one more cycle: cyc_cnt=0. Then assert RST at phase 2: all outputs 0 immediately, with no edge needed.
